// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-agreement debouncer,
// and a press/short/long classifier that emits single-cycle event strobes.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_short,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  state_t        state;
  logic          flip, rise, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The flip edge is also the edge the FSM sees rise/fall, so press/release
  // land on the same edge as the level change.
  assign flip = (s2 != btn_level) && (db_cnt == DB_LAST);
  assign rise = flip &  s2;
  assign fall = flip & ~s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else if (s2 != btn_level) begin
      if (flip) begin
        btn_level <= s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_short   <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_short   <= 1'b0;
      btn_long    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= PRESSED;
            hold_cnt  <= '0;
            btn_press <= 1'b1;
          end
        end
        PRESSED: begin
          // A fall on the threshold edge wins over the long classification.
          if (fall) begin
            state       <= IDLE;
            btn_release <= 1'b1;
            btn_short   <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= HELD;
            btn_long <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state       <= IDLE;
            btn_release <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
